// File: rtl/burst_memory.sv
// Byte-addressable little-endian memory with 1/4/8/16-word burst reads and writes.
// Define MEM_BOUNDS_CHECK_EN to reject out-of-range requests with an err pulse.
module burst_memory #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            access_size,
    input  logic                  rw,
    input  logic                  enable,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  err
);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = ADDR_WIDTH + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;

    logic [7:0]            mem_q [DEPTH];
    logic [1:0]            state_q, state_d;
    logic [3:0]            rem_q, rem_d, n_m1;
    logic [IW-1:0]         idx_q, idx_d, beat_idx, start_idx;
    logic [ADDR_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d, rd_word;
    logic                  rd_valid_q, rd_valid_d;
    logic                  do_rd, do_wr, reject, err_d;
    logic                  unused_bits;

    assign offset    = {address[ADDR_WIDTH-1:2], 2'b00} - START_ADDR;
    assign start_idx = offset[IW-1:0];

    always_comb begin
        case (access_size)
            2'b00:   n_m1 = 4'd0;
            2'b01:   n_m1 = 4'd3;
            2'b10:   n_m1 = 4'd7;
            default: n_m1 = 4'd15;
        endcase
    end

`ifdef MEM_BOUNDS_CHECK_EN
    logic [SW-1:0] span_end;
    logic          err_q;

    // Span is computed one bit wider so a request near the top of the address space cannot wrap.
    assign span_end = {1'b0, address - START_ADDR} + SW'({n_m1, 2'b00}) + SW'(4);
    assign reject   = (address < START_ADDR) || (span_end > SW'(DEPTH));

    always_ff @(posedge clock) begin
        if (!resetn) err_q <= 1'b0;
        else         err_q <= err_d;
    end
    assign err         = err_q;
    assign unused_bits = ^{address[1:0], offset[ADDR_WIDTH-1:IW]};
`else
    assign reject      = 1'b0;
    assign err         = 1'b0;
    assign unused_bits = ^{address[1:0], offset[ADDR_WIDTH-1:IW], err_d};
`endif

    assign rd_word = {mem_q[beat_idx + IW'(3)], mem_q[beat_idx + IW'(2)],
                      mem_q[beat_idx + IW'(1)], mem_q[beat_idx]};

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        beat_idx = idx_q + IW'(4);
        do_rd    = 1'b0;
        do_wr    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        beat_idx = start_idx;
                        idx_d    = start_idx;
                        rem_d    = n_m1;
                        do_rd    = rw;
                        do_wr    = !rw;
                        if (n_m1 != 4'd0) state_d = rw ? RD : WR;
                    end
                end
            end
            RD, WR: begin
                do_rd = (state_q == RD);
                do_wr = (state_q == WR);
                idx_d = beat_idx;
                rem_d = rem_q - 4'd1;
                if (rem_q == 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rd_valid_d = do_rd;
        data_out_d = do_rd ? rd_word : data_out_q;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            idx_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Array is never reset; reset only blocks the write on its own edge.
    always_ff @(posedge clock) begin
        if (resetn && do_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                mem_q[beat_idx + IW'(b)] <= data_in[8*b +: 8];
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
endmodule
